// File: rtl/add_arbiter_pkg.sv
// Shared types and sizing helpers for the add_arbiter slice.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_W    = 16;
  localparam int DEF_NREQ = 4;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping modulo NREQ.
module rr_pick
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Offset 1 is searched first so the previous winner has lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sequencing one registered W-bit adder among NREQ requesters.
// Build option: ADD_ARBITER_SAT_EN saturates the sum to all ones on carry out.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [W-1:0]              rsp_sum,
  output logic                      rsp_carry,
  output logic                      busy,
  output state_t                    dbg_state
);

  localparam int IW = id_width(NREQ);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; req_ready is a one-hot accept strobe in IDLE only, rsp_* hold until taken.
  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, sel_a, sel_b, sum_res;
  logic [IW-1:0]   id_q, last_grant, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [W:0]      full_sum;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    full_sum = {1'b0, a_q} + {1'b0, b_q};
`ifdef ADD_ARBITER_SAT_EN
    sum_res = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];
`else
    sum_res = full_sum[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? pick_gnt : '0;
    busy      = (state == EXEC) || (state == RESP);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      last_grant <= IW'(NREQ - 1);
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          a_q  <= sel_a;
          b_q  <= sel_b;
          id_q <= pick_idx;
        end
        EXEC: begin
          rsp_sum   <= sum_res;
          rsp_carry <= full_sum[W];
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_valid && rsp_ready) begin
          rsp_valid  <= 1'b0;
          last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_add_arbiter;
  import add_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry, busy;
  state_t            dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [IW+W:0] exp_q[$];

  add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    int          stall;
    logic [1:0]  exp_id;
    logic [15:0] exp_sum;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Winner gets the given operands, every other requester gets scrambled ones.
  task automatic drive_ops(input logic [3:0] mask, input int win,
                           input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = (i == win) ? a : (a ^ 16'h5A5A);
      req_b[i*W +: W] = (i == win) ? b : (b ^ 16'hA5A5);
    end
    req_valid = mask;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [IW+W:0] got, exp, held;
    string tag;
    tag = $sformatf("v%0d", n);
    exp_q.push_back({v.exp_id, v.exp_carry, v.exp_sum});
    @(negedge clk);
    rsp_ready = (v.stall == 0);
    drive_ops(v.mask, int'(v.exp_id), v.a, v.b);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << v.exp_id));
    @(negedge clk);
    req_valid = '0;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    #1;
    chk({tag, "_exec"}, {busy, rsp_valid, req_ready}, 6'b100000);
    @(negedge clk);
    #1;
    got = {rsp_id, rsp_carry, rsp_sum};
    exp = exp_q.pop_front();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp"}, 32'(got), 32'(exp));
    held = got;
    if (v.stall > 0) begin
      for (int k = 1; k < v.stall; k++) begin
        @(negedge clk);
        #1;
        chk({tag, "_hold"}, {req_ready, rsp_valid, rsp_id, rsp_carry, rsp_sum},
            {4'b0000, 1'b1, held});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk({tag, "_hold_last"}, {req_ready, rsp_valid, rsp_id, rsp_carry, rsp_sum},
          {4'b0000, 1'b1, held});
    end
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    int order[5];
    int n, last_cyc;
    logic [IW+W:0] held;

    order = '{0, 1, 2, 3, 0};
    vecs[0] = '{4'b0100, 16'h0003, 16'h0004, 0, 2'd2, 16'h0007, 1'b0};
    vecs[1] = '{4'b0001, 16'h1234, 16'h1111, 0, 2'd0, 16'h2345, 1'b0};
`ifdef ADD_ARBITER_SAT_EN
    vecs[2] = '{4'b1111, 16'hFFFF, 16'h0001, 0, 2'd1, 16'hFFFF, 1'b1};
    vecs[3] = '{4'b1001, 16'h8000, 16'h8000, 0, 2'd3, 16'hFFFF, 1'b1};
`else
    vecs[2] = '{4'b1111, 16'hFFFF, 16'h0001, 0, 2'd1, 16'h0000, 1'b1};
    vecs[3] = '{4'b1001, 16'h8000, 16'h8000, 0, 2'd3, 16'h0000, 1'b1};
`endif
    vecs[4] = '{4'b1001, 16'h7FFF, 16'h0001, 0, 2'd0, 16'h8000, 1'b0};
    vecs[5] = '{4'b0110, 16'hABCD, 16'h1234, 5, 2'd1, 16'hBE01, 1'b0};
`ifdef ADD_ARBITER_SAT_EN
    vecs[6] = '{4'b0001, 16'hFFFF, 16'hFFFF, 0, 2'd0, 16'hFFFF, 1'b1};
`else
    vecs[6] = '{4'b0001, 16'hFFFF, 16'hFFFF, 0, 2'd0, 16'hFFFE, 1'b1};
`endif

    // Reset values.
    do_reset();
    chk("reset_outs", {req_ready, rsp_valid, busy, rsp_id, rsp_carry, rsp_sum}, '0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));

    // All four requesters valid continuously, rsp_ready high.
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 16'(i + 1);
      req_b[i*W +: W] = 16'(i * 16);
    end
    req_valid = 4'b1111;
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && (n < 5 || exp_q.size() > 0); cyc++) begin
      #1;
      chk("onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (rsp_valid) begin
        held = exp_q.pop_front();
        chk("rr_rsp", {rsp_id, rsp_carry, rsp_sum}, held);
      end
      if (req_ready != 0 && n < 5) begin
        chk("rr_order", 32'(req_ready), 32'(4'b0001 << order[n]));
        if (n > 0) chk("rr_gap", cyc - last_cyc, 3);
        exp_q.push_back({2'(order[n]), 1'b0, 16'(17 * order[n] + 1)});
        last_cyc = cyc;
        n++;
      end
      @(negedge clk);
      if (n == 5) req_valid = '0;
    end
    chk("rr_accepts", n, 5);
    chk("rr_drained", exp_q.size(), 0);
    exp_q.delete();

    // Vector table, starting from a fresh reset.
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure with a second requester waiting; last grant is 0 here.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    req_a[1*W +: W] = 16'h0100;
    req_b[1*W +: W] = 16'h0020;
    req_a[2*W +: W] = 16'h0005;
    req_b[2*W +: W] = 16'h0006;
    req_valid = 4'b0110;
    #1;
    chk("bp_grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    #1;
    chk("bp_exec_noready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 2'd1, 1'b0, 16'h0120});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", {req_ready, rsp_valid, rsp_id, rsp_carry, rsp_sum},
          {4'b0000, 1'b1, 2'd1, 1'b0, 16'h0120});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_cycle", {req_ready, rsp_valid}, 5'b00001);
    @(negedge clk);
    #1;
    chk("bp_next_accept", {req_ready, rsp_valid}, 5'b01000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_rsp2", {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 2'd2, 1'b0, 16'h000B});
    @(negedge clk);

    // Reset during EXEC; last grant is 2, so a stale pointer would pick 3.
    drive_ops(4'b0001, 0, 16'h1111, 16'h2222);
    #1;
    chk("mr_grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mr_in_exec", 32'(dbg_state), 32'(EXEC));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_outs_zero", {req_ready, rsp_valid, busy, rsp_id, rsp_carry, rsp_sum}, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("mr_no_rsp", {rsp_valid, busy}, 2'b00);
    end
    @(negedge clk);
    drive_ops(4'b1010, 1, 16'h0001, 16'h0002);
    #1;
    chk("mr_grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("mr_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 2'd1, 1'b0, 16'h0003});
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
